// File: rtl/mux_scan_capture.sv
// mux_scan_capture: steps the 8-to-1 mux select through 0..7, samples the mux
// output Y on the last cycle of each DIV-cycle step, and presents the assembled
// byte with a one-cycle valid strobe.
// Optional feature macro: SCAN_PARITY_EN adds a registered parity output
// (XOR of the captured byte), updated together with data.
module mux_scan_capture #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             y_in,
    output logic [SEL_W-1:0] sel,
    output logic [7:0]       data,
    output logic             valid,
    output logic             busy
`ifdef SCAN_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic [7:0]       data_d;
    logic             valid_d;
    logic             busy_d;

    // Select is the zero-extended step index; the top bit stays 0.
    assign sel = SEL_W'(idx_q);

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data    <= 8'h00;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data    <= data_d;
            valid   <= valid_d;
            busy    <= busy_d;
        end
    end

`ifdef SCAN_PARITY_EN
    // Parity of the byte, refreshed only when a completed scan is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (valid_d) begin
            parity <= ^data_d;
        end
    end
`endif

    // Next-state: step timing, sample capture and end-of-scan handling.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data;
        valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                    shift_d = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = y_in;
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        // Last sample: publish the byte including this sample.
                        data_d  = shift_d;
                        valid_d = 1'b1;
                        idx_d   = '0;
                        if (!cont) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

endmodule
